// File: rtl/mem_seq_ctrl_if.sv
// rtl/mem_seq_ctrl_if.sv - request and memory bus bundle for mem_seq_ctrl
//
// Groups every signal of mem_seq_ctrl except clk and proc_rst.
//   Request side : req, op[1:0], base_addr[5:0], reg_mask[7:0], wdata[15:0]
//   Memory side  : mem_out[15:0] in; mem_addr[5:0], mem_in[15:0],
//                  mem_write_n, mem_read_n out
//   Status side  : cur_idx[2:0], rdata[15:0], rdata_valid, rd_idx[2:0],
//                  busy, done
// master : the environment (request issuer plus memory model)
// slave  : the sequencer itself
interface mem_seq_ctrl_if;
    logic        req;
    logic [1:0]  op;
    logic [5:0]  base_addr;
    logic [7:0]  reg_mask;
    logic [15:0] wdata;
    logic [15:0] mem_out;

    logic [5:0]  mem_addr;
    logic [15:0] mem_in;
    logic        mem_write_n;
    logic        mem_read_n;
    logic [2:0]  cur_idx;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic [2:0]  rd_idx;
    logic        busy;
    logic        done;

    modport master (
        output req, op, base_addr, reg_mask, wdata, mem_out,
        input  mem_addr, mem_in, mem_write_n, mem_read_n, cur_idx,
               rdata, rdata_valid, rd_idx, busy, done
    );

    modport slave (
        input  req, op, base_addr, reg_mask, wdata, mem_out,
        output mem_addr, mem_in, mem_write_n, mem_read_n, cur_idx,
               rdata, rdata_valid, rd_idx, busy, done
    );
endinterface

// File: rtl/mem_seq_ctrl.sv
// rtl/mem_seq_ctrl.sv - single and load/store-multiple memory access sequencer
//
// Ports:
//   clk       : single clock, all state changes on posedge
//   proc_rst  : synchronous active-high reset
//   bus       : mem_seq_ctrl_if.slave
//                 req/op/base_addr/reg_mask accepted only in IDLE
//                 wdata feeds mem_in combinationally during a write access
//                 mem_out is captured into rdata at the end of a read access
//                 strobes, mem_addr and cur_idx are decoded from registered state
//                 busy is high outside IDLE, done pulses for the DONE cycle
//
// Operation codes: 00 single read, 01 single write, 10 load multiple,
// 11 store multiple. op[0] selects write, op[1] selects the multiple form.
// One ACCESS cycle is spent per set bit of the register mask, lowest bit
// first, with the word address incrementing modulo 64.
module mem_seq_ctrl (
    input  logic           clk,
    input  logic           proc_rst,
    mem_seq_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;

    logic [1:0]  op_q, op_d;
    logic [5:0]  addr_q, addr_d;
    logic [7:0]  mask_q, mask_d;
    logic [15:0] rdata_q, rdata_d;
    logic [2:0]  rd_idx_q, rd_idx_d;
    logic        rdata_valid_q, rdata_valid_d;

    // Last values driven during ACCESS, replayed on the bus in IDLE/DONE so
    // the address/data/index lines do not toggle between transfers.
    logic [5:0]  addr_hold_q, addr_hold_d;
    logic [15:0] wdata_hold_q, wdata_hold_d;
    logic [2:0]  idx_hold_q, idx_hold_d;

    logic [2:0]  low_idx;
    logic [7:0]  mask_clr;
    logic        is_read;
    logic        in_access;

    // Lowest set bit of the remaining mask; scanning from the top down lets
    // the lowest hit overwrite any higher one.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    assign mask_clr  = mask_q & ~(8'd1 << low_idx);
    assign is_read   = ~op_q[0];
    assign in_access = (state_q == S_ACCESS);

    // State register
    always_ff @(posedge clk) begin
        if (proc_rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    // An empty list on a multiple op has nothing to transfer.
                    if (bus.op[1] && (bus.reg_mask == 8'd0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_ACCESS: begin
                if (mask_clr == 8'd0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath next values
    always_comb begin
        op_d          = op_q;
        addr_d        = addr_q;
        mask_d        = mask_q;
        rdata_d       = rdata_q;
        rd_idx_d      = rd_idx_q;
        rdata_valid_d = 1'b0;
        addr_hold_d   = addr_hold_q;
        wdata_hold_d  = wdata_hold_q;
        idx_hold_d    = idx_hold_q;

        unique case (state_q)
            S_IDLE: begin
                if (bus.req) begin
                    op_d   = bus.op;
                    addr_d = bus.base_addr;
                    // Single ops behave as a one-entry list for register 0.
                    mask_d = bus.op[1] ? bus.reg_mask : 8'h01;
                end
            end
            S_ACCESS: begin
                mask_d      = mask_clr;
                addr_d      = addr_q + 6'd1;
                addr_hold_d = addr_q;
                idx_hold_d  = low_idx;
                if (is_read) begin
                    // Memory samples the read strobe on the negedge, so
                    // mem_out is settled by the posedge closing this cycle.
                    rdata_d       = bus.mem_out;
                    rd_idx_d      = low_idx;
                    rdata_valid_d = 1'b1;
                end else begin
                    wdata_hold_d = bus.wdata;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (proc_rst) begin
            op_q          <= 2'd0;
            addr_q        <= 6'd0;
            mask_q        <= 8'd0;
            rdata_q       <= 16'd0;
            rd_idx_q      <= 3'd0;
            rdata_valid_q <= 1'b0;
            addr_hold_q   <= 6'd0;
            wdata_hold_q  <= 16'd0;
            idx_hold_q    <= 3'd0;
        end else begin
            op_q          <= op_d;
            addr_q        <= addr_d;
            mask_q        <= mask_d;
            rdata_q       <= rdata_d;
            rd_idx_q      <= rd_idx_d;
            rdata_valid_q <= rdata_valid_d;
            addr_hold_q   <= addr_hold_d;
            wdata_hold_q  <= wdata_hold_d;
            idx_hold_q    <= idx_hold_d;
        end
    end

    // Output decode from registered state
    always_comb begin
        bus.mem_read_n  = ~(in_access & is_read);
        bus.mem_write_n = ~(in_access & ~is_read);
        bus.mem_addr    = in_access ? addr_q : addr_hold_q;
        bus.cur_idx     = in_access ? low_idx : idx_hold_q;
        bus.mem_in      = (in_access && !is_read) ? bus.wdata : wdata_hold_q;
        bus.rdata       = rdata_q;
        bus.rd_idx      = rd_idx_q;
        bus.rdata_valid = rdata_valid_q;
        bus.busy        = (state_q != S_IDLE);
        bus.done        = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// tb/tb_mem_seq_ctrl.sv - randomized self-checking bench for mem_seq_ctrl
module tb_mem_seq_ctrl;

    logic clk = 1'b0;
    logic proc_rst;

    always #5 clk = ~clk;

    mem_seq_ctrl_if bus ();

    mem_seq_ctrl dut (
        .clk      (clk),
        .proc_rst (proc_rst),
        .bus      (bus)
    );

    logic [15:0] mem     [64];
    logic [15:0] ref_mem [64];

    int total = 0;
    int bad   = 0;

    // Memory model: acts on the strobes at negedge.
    always @(negedge clk) begin
        if (!bus.mem_write_n) mem[bus.mem_addr] = bus.mem_in;
        if (!bus.mem_read_n)  bus.mem_out <= mem[bus.mem_addr];
    end

    // One transaction: issues the request, then checks every cycle up to
    // and including the first IDLE cycle against a list-based expectation.
    task automatic run_op(input logic [1:0] o, input logic [5:0] base,
                          input logic [7:0] msk, input logic [15:0] wbase,
                          input bit poke_req);
        int          idxs[$];
        int          n;
        bit          rd;
        logic [5:0]  a;
        logic [15:0] wd;
        logic [15:0] last_data;
        logic [2:0]  last_idx;
        rd        = (o[0] == 1'b0);
        last_data = 16'd0;
        last_idx  = 3'd0;
        if (o[1]) begin
            for (int i = 0; i < 8; i++) if (msk[i]) idxs.push_back(i);
        end else begin
            idxs.push_back(0);
        end
        n = idxs.size();

        bus.req = 1'b1; bus.op = o; bus.base_addr = base; bus.reg_mask = msk;
        @(posedge clk); #1;
        // Scramble request inputs to show they were latched.
        bus.req = 1'b0; bus.op = 2'($urandom); bus.base_addr = 6'($urandom);
        bus.reg_mask = 8'($urandom);

        for (int k = 0; k < n; k++) begin
            a  = base + 6'(k);
            wd = wbase + 16'(k) * 16'h0101;
            bus.wdata = wd;
            @(negedge clk);
            total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL acc_busy op=%0d k=%0d got=%b exp=1", o, k, bus.busy); end
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL acc_done op=%0d k=%0d got=%b exp=0", o, k, bus.done); end
            total++; if (bus.mem_read_n !== !rd) begin bad++; $display("FAIL acc_read_n op=%0d k=%0d got=%b exp=%b", o, k, bus.mem_read_n, !rd); end
            total++; if (bus.mem_write_n !== rd) begin bad++; $display("FAIL acc_write_n op=%0d k=%0d got=%b exp=%b", o, k, bus.mem_write_n, rd); end
            total++; if (bus.mem_addr !== a) begin bad++; $display("FAIL acc_addr op=%0d k=%0d got=%0d exp=%0d", o, k, bus.mem_addr, a); end
            total++; if (bus.cur_idx !== 3'(idxs[k])) begin bad++; $display("FAIL acc_cur_idx op=%0d k=%0d got=%0d exp=%0d", o, k, bus.cur_idx, idxs[k]); end
            if (!rd) begin
                total++; if (bus.mem_in !== wd) begin bad++; $display("FAIL acc_mem_in k=%0d got=%h exp=%h", k, bus.mem_in, wd); end
            end
            total++; if (bus.rdata_valid !== (rd && k > 0)) begin bad++; $display("FAIL acc_rvalid op=%0d k=%0d got=%b exp=%b", o, k, bus.rdata_valid, (rd && k > 0)); end
            if (rd && k > 0) begin
                total++; if (bus.rdata !== last_data) begin bad++; $display("FAIL acc_rdata k=%0d got=%h exp=%h", k, bus.rdata, last_data); end
                total++; if (bus.rd_idx !== last_idx) begin bad++; $display("FAIL acc_rd_idx k=%0d got=%0d exp=%0d", k, bus.rd_idx, last_idx); end
            end
            if (rd) begin
                last_data = ref_mem[a];
                last_idx  = 3'(idxs[k]);
            end else begin
                ref_mem[a] = wd;
            end
            if (poke_req && k == 0) begin
                bus.req = 1'b1; bus.op = 2'($urandom); bus.reg_mask = 8'($urandom);
            end
            @(posedge clk); #1;
            bus.req = 1'b0;
        end

        // DONE cycle
        @(negedge clk);
        total++; if (bus.done !== 1'b1) begin bad++; $display("FAIL done_pulse op=%0d n=%0d got=%b exp=1", o, n, bus.done); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL done_busy op=%0d got=%b exp=1", o, bus.busy); end
        total++; if ({bus.mem_read_n, bus.mem_write_n} !== 2'b11) begin bad++; $display("FAIL done_strobes got=%b exp=11", {bus.mem_read_n, bus.mem_write_n}); end
        total++; if (bus.rdata_valid !== (rd && n > 0)) begin bad++; $display("FAIL done_rvalid op=%0d n=%0d got=%b exp=%b", o, n, bus.rdata_valid, (rd && n > 0)); end
        if (rd && n > 0) begin
            total++; if (bus.rdata !== last_data) begin bad++; $display("FAIL done_rdata got=%h exp=%h", bus.rdata, last_data); end
            total++; if (bus.rd_idx !== last_idx) begin bad++; $display("FAIL done_rd_idx got=%0d exp=%0d", bus.rd_idx, last_idx); end
        end
        @(posedge clk); #1;

        // First IDLE cycle
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL idle_busy op=%0d got=%b exp=0", o, bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL idle_done got=%b exp=0", bus.done); end
        total++; if (bus.rdata_valid !== 1'b0) begin bad++; $display("FAIL idle_rvalid got=%b exp=0", bus.rdata_valid); end
        total++; if ({bus.mem_read_n, bus.mem_write_n} !== 2'b11) begin bad++; $display("FAIL idle_strobes got=%b exp=11", {bus.mem_read_n, bus.mem_write_n}); end
    endtask

    task automatic test_reset();
        proc_rst = 1'b1;
        bus.req = 1'b1; bus.op = 2'b10; bus.base_addr = 6'd9; bus.reg_mask = 8'hFF;
        bus.wdata = 16'hBEEF;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", bus.done); end
        total++; if ({bus.mem_read_n, bus.mem_write_n} !== 2'b11) begin bad++; $display("FAIL rst_strobes got=%b exp=11", {bus.mem_read_n, bus.mem_write_n}); end
        total++; if (bus.mem_addr !== 6'd0) begin bad++; $display("FAIL rst_mem_addr got=%0d exp=0", bus.mem_addr); end
        total++; if (bus.mem_in !== 16'd0) begin bad++; $display("FAIL rst_mem_in got=%h exp=0", bus.mem_in); end
        total++; if (bus.cur_idx !== 3'd0) begin bad++; $display("FAIL rst_cur_idx got=%0d exp=0", bus.cur_idx); end
        total++; if (bus.rdata !== 16'd0) begin bad++; $display("FAIL rst_rdata got=%h exp=0", bus.rdata); end
        total++; if (bus.rd_idx !== 3'd0) begin bad++; $display("FAIL rst_rd_idx got=%0d exp=0", bus.rd_idx); end
        total++; if (bus.rdata_valid !== 1'b0) begin bad++; $display("FAIL rst_rvalid got=%b exp=0", bus.rdata_valid); end
        proc_rst = 1'b0;
        bus.req  = 1'b0;
    endtask

    task automatic test_single_read();
        mem[20] = 16'h0001; ref_mem[20] = 16'h0001;
        run_op(2'b00, 6'd20, 8'($urandom), 16'($urandom), 1'b0);
    endtask

    task automatic test_single_write();
        run_op(2'b01, 6'd23, 8'($urandom), 16'h0005, 1'b0);
        run_op(2'b00, 6'd23, 8'($urandom), 16'($urandom), 1'b0);
    endtask

    task automatic test_lm();
        run_op(2'b10, 6'd2, 8'b0000_1101, 16'($urandom), 1'b0);
    endtask

    task automatic test_sm_wrap();
        run_op(2'b11, 6'd62, 8'h07, 16'($urandom), 1'b0);
        run_op(2'b10, 6'd62, 8'h07, 16'($urandom), 1'b0);
    endtask

    task automatic test_empty_and_ignored();
        run_op(2'b10, 6'($urandom), 8'h00, 16'($urandom), 1'b0);
        run_op(2'b11, 6'($urandom), 8'h00, 16'($urandom), 1'b0);
        run_op(2'b10, 6'($urandom), 8'hF0, 16'($urandom), 1'b1);
        run_op(2'b11, 6'($urandom), 8'h81, 16'($urandom), 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] m;
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 3))
                0:       m = 8'h00;
                1:       m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            run_op(2'($urandom), 6'($urandom), m, 16'($urandom), 1'($urandom));
        end
    endtask

    task automatic test_reset_mid();
        bus.req = 1'b1; bus.op = 2'b10; bus.base_addr = 6'($urandom); bus.reg_mask = 8'b0101_1010;
        @(posedge clk); #1;
        bus.req = 1'b0;
        @(posedge clk); #1;
        proc_rst = 1'b1;
        @(posedge clk); #1;
        proc_rst = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
        total++; if ({bus.mem_read_n, bus.mem_write_n} !== 2'b11) begin bad++; $display("FAIL abort_strobes got=%b exp=11", {bus.mem_read_n, bus.mem_write_n}); end
        total++; if (bus.rdata !== 16'd0) begin bad++; $display("FAIL abort_rdata got=%h exp=0", bus.rdata); end
        for (int c = 0; c < 4; c++) begin
            total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_done c=%0d got=%b exp=0", c, bus.done); end
            total++; if (bus.rdata_valid !== 1'b0) begin bad++; $display("FAIL abort_rvalid c=%0d got=%b exp=0", c, bus.rdata_valid); end
            @(negedge clk);
        end
    endtask

    initial begin
        bus.req = 1'b0; bus.op = 2'd0; bus.base_addr = 6'd0; bus.reg_mask = 8'd0;
        bus.wdata = 16'd0;
        proc_rst = 1'b1;
        for (int i = 0; i < 64; i++) begin
            mem[i]     = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_single_read();
        test_single_write();
        test_lm();
        test_sm_wrap();
        test_empty_and_ignored();
        test_back_to_back();
        test_reset_mid();
        test_single_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_seq_ctrl.md
MEM_SEQ_CTRL -- requirements
Module: mem_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-002 SHALL have port proc_rst, input, 1 bit: synchronous active-high reset, sampled on posedge clk.
REQ-003 SHALL have port req, input, 1 bit: start request, sampled only in IDLE.
REQ-004 SHALL have port op, input, 2 bits: operation code.
  - 00 single read
  - 01 single write
  - 10 multiple read (LM)
  - 11 multiple write (SM)
REQ-005 SHALL have port base_addr, input, 6 bits: first word address.
REQ-006 SHALL have port reg_mask, input, 8 bits: LM/SM register list, bit i = register i; ignored for single ops.
REQ-007 SHALL have port wdata, input, 16 bits: store data for cur_idx, valid in the same cycle.
REQ-008 SHALL have port mem_out, input, 16 bits: read data returned by memory.
REQ-009 SHALL have port mem_addr, output, 6 bits: memory word address.
REQ-010 SHALL have port mem_in, output, 16 bits: memory write data.
REQ-011 SHALL have port mem_write_n, output, 1 bit: active-low write strobe.
REQ-012 SHALL have port mem_read_n, output, 1 bit: active-low read strobe.
REQ-013 SHALL have port cur_idx, output, 3 bits: register index of the current access.
REQ-014 SHALL have port rdata, output, 16 bits: captured read word.
REQ-015 SHALL have port rdata_valid, output, 1 bit: one-cycle pulse qualifying rdata.
REQ-016 SHALL have port rd_idx, output, 3 bits: register index of rdata.
REQ-017 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-018 SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, DONE; all memory-side outputs are decoded from registered state only (Moore), never from req.
REQ-020 SHALL, in IDLE with req=1, latch op, base_addr into addr_q and reg_mask into mask_q.
  - Single op: mask_q is forced to 8'h01.
  - Next state is ACCESS, or DONE if the op is multiple and reg_mask=0.
REQ-021 SHALL ignore req in ACCESS and DONE (no queuing).
REQ-022 SHALL, in ACCESS, set cur_idx to the lowest set bit of mask_q and mem_addr to addr_q.
  - Read op: mem_read_n=0.
  - Write op: mem_write_n=0 and mem_in=wdata.
  - Exactly one strobe is low.
REQ-023 SHALL, at each posedge in ACCESS:
  - clear bit cur_idx of mask_q;
  - increment addr_q modulo 64 (63 -> 0, no error);
  - go to DONE if the cleared mask is zero, else stay in ACCESS.
REQ-024 SHALL, for read ops, register mem_out into rdata and cur_idx into rd_idx at the posedge ending each ACCESS cycle, and assert rdata_valid for the following cycle only.
  - Memory captures the strobe on negedge clk, so data is stable at that posedge.
REQ-025 SHALL never assert rdata_valid for write ops.
REQ-026 SHALL assert done for exactly the one cycle spent in DONE, then return to IDLE.
  - For read ops, the final rdata_valid coincides with done.
REQ-027 SHALL hold mem_read_n=1 and mem_write_n=1 in IDLE and DONE; mem_addr, mem_in and cur_idx are don't-care there but held at their last value.
REQ-028 SHALL take 1 + N + 1 cycles from the accepting edge to the return to IDLE, for N set mask bits (N=1 for single ops, N=0 for an empty mask).
REQ-029 SHALL allow a new req in the first IDLE cycle after DONE; the minimum request spacing is N+2 cycles.

Reset
REQ-030 SHALL, on proc_rst=1 at posedge, force IDLE; mask_q=0; addr_q=0; rdata=0; rd_idx=0; rdata_valid=0; done=0; mem_read_n=1; mem_write_n=1; mem_addr=0; mem_in=0; cur_idx=0.
REQ-031 SHALL let proc_rst win over req and over any mid-transfer state: no done or rdata_valid follows an aborted transfer, and strobes are high in the first cycle after the reset edge.

Verification
REQ-032 SHALL cover single read: memory preloaded mem[20]=16'h0001; req, op=00, base_addr=20 -> mem_read_n low 1 cycle with mem_addr=20; next cycle rdata=16'h0001, rd_idx=0, rdata_valid=1, done=1.
REQ-033 SHALL cover single write: op=01, base_addr=23, wdata=16'h0005 -> mem_write_n low 1 cycle; later single read of 23 returns 16'h0005.
REQ-034 SHALL cover LM: op=10, base_addr=2, reg_mask=8'b00001101 -> 3 ACCESS cycles at addresses 2,3,4; rd_idx sequence 0,2,3; done coincides with the third rdata_valid; busy high 4 cycles.
REQ-035 SHALL cover SM with wrap: op=11, base_addr=62, reg_mask=8'h07 -> writes at addresses 62,63,0 with cur_idx 0,1,2.
REQ-036 SHALL cover empty mask and ignored request:
  - op=10, reg_mask=0 -> done one cycle after acceptance, no strobe ever low.
  - req pulsed during ACCESS -> no effect.
REQ-037 SHALL cover reset mid-LM: proc_rst asserted in the second ACCESS cycle of a 4-register LM -> next cycle IDLE, strobes high, busy=0, no done or further rdata_valid.
